// File: rtl/ifm_pkg.sv
// ifm_pkg: shared defaults and storage types for the IFM chunk ring buffer
package ifm_pkg;
  localparam int IFM_BUS_SIZE   = 32;
  localparam int IFM_CHUNK_SIZE = 128;
  localparam int IFM_SLOT_NUM   = 4;
  localparam int IFM_DATA_W     = 8;
  localparam int IFM_BEAT_NUM   = IFM_CHUNK_SIZE / IFM_BUS_SIZE;
  typedef struct packed {
    logic [IFM_BUS_SIZE-1:0]            sparsemap;
    logic [IFM_BUS_SIZE*IFM_DATA_W-1:0] nonzero_data;
  } ifm_beat_t;
  typedef logic [$clog2(IFM_BEAT_NUM)-1:0] beat_idx_t;
  typedef logic [$clog2(IFM_SLOT_NUM)-1:0] slot_idx_t;
endpackage

// File: rtl/ifm_clk_gate.sv
// ifm_clk_gate: latch-based clock gate for the chunk storage (built with IFM_CHUNK_RING_BUF_CLK_GATE_EN)
//   clk_i in, en_i in (sampled while clk_i low), gated_clk_o out
`ifdef IFM_CHUNK_RING_BUF_CLK_GATE_EN
module ifm_clk_gate (
  input  logic clk_i,
  input  logic en_i,
  output logic gated_clk_o
);
  logic en_l;
  always_latch if (!clk_i) en_l <= en_i;
  assign gated_clk_o = clk_i & en_l;
endmodule
`endif

// File: rtl/ifm_chunk_ring_buf.sv
// ifm_chunk_ring_buf: ring of SLOT_NUM chunk slots, DMA writes beats in, PE reads/releases the oldest chunk
//   write: wr_valid_i/wr_ready_o, wr_sparsemap_i, wr_nonzero_data_i
//   read : rd_chunk_valid_o, rd_en_i, rd_beat_i -> rd_data_valid_o, rd_sparsemap_o, rd_nonzero_data_o (registered)
//   ctrl : clk_i, rst_ni (async, active-low), flush_i (sync clear), rd_release_i, occupancy_o
//   IFM_CHUNK_RING_BUF_CLK_GATE_EN: storage clocked through ifm_clk_gate instead of enable flops
//   Storage word and index types come from ifm_pkg; size overrides belong there.
module ifm_chunk_ring_buf
  import ifm_pkg::*;
#(
  parameter int BUS_SIZE   = IFM_BUS_SIZE,
  parameter int CHUNK_SIZE = IFM_CHUNK_SIZE,
  parameter int SLOT_NUM   = IFM_SLOT_NUM,
  parameter int DATA_W     = IFM_DATA_W
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic                             wr_valid_i,
  output logic                             wr_ready_o,
  input  logic [BUS_SIZE-1:0]              wr_sparsemap_i,
  input  logic [BUS_SIZE*DATA_W-1:0]       wr_nonzero_data_i,
  output logic                             rd_chunk_valid_o,
  input  logic                             rd_en_i,
  input  logic [$clog2(CHUNK_SIZE/BUS_SIZE)-1:0] rd_beat_i,
  output logic                             rd_data_valid_o,
  output logic [BUS_SIZE-1:0]              rd_sparsemap_o,
  output logic [BUS_SIZE*DATA_W-1:0]       rd_nonzero_data_o,
  input  logic                             rd_release_i,
  output logic [$clog2(SLOT_NUM+1)-1:0]    occupancy_o
);
  localparam int BEAT_NUM = CHUNK_SIZE / BUS_SIZE;
  localparam int OW = $clog2(SLOT_NUM + 1);
  ifm_beat_t mem [SLOT_NUM][BEAT_NUM];
  ifm_beat_t rd_word;
  logic [SLOT_NUM-1:0] full, full_n;
  slot_idx_t wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  beat_idx_t wr_beat, wr_beat_n;
  logic [OW-1:0] occ_n;
  logic [BUS_SIZE-1:0] rd_sm_n;
  logic [BUS_SIZE*DATA_W-1:0] rd_nz_n;
  logic wr_acc, last, done, rel, rd_fire, rd_dv_n, gated_clk_w;
  // ready and head-valid look only at registered state, so a slot freed this cycle is writable next cycle
  assign wr_ready_o       = !full[wr_ptr];
  assign rd_chunk_valid_o = full[rd_ptr];
  assign wr_acc  = wr_valid_i & wr_ready_o & !flush_i;
  assign last    = wr_beat == beat_idx_t'(BEAT_NUM - 1);
  assign done    = wr_acc & last;
  assign rel     = rd_release_i & rd_chunk_valid_o;
  assign rd_fire = rd_en_i & rd_chunk_valid_o;
  assign rd_word = mem[rd_ptr][rd_beat_i];
  // completing slot is empty and released slot is full, so the two never collide
  always_comb begin
    full_n = full;
    if (done) full_n[wr_ptr] = 1'b1;
    if (rel) full_n[rd_ptr] = 1'b0;
    if (flush_i) full_n = '0;
  end
  assign wr_ptr_n  = flush_i ? '0 : done ? wr_ptr + 1'b1 : wr_ptr;
  assign rd_ptr_n  = flush_i ? '0 : rel ? rd_ptr + 1'b1 : rd_ptr;
  assign wr_beat_n = flush_i ? '0 : !wr_acc ? wr_beat : last ? '0 : wr_beat + 1'b1;
  assign occ_n     = flush_i ? '0 : occupancy_o + OW'(done) - OW'(rel);
  assign rd_dv_n   = rd_fire & !flush_i;
  assign rd_sm_n   = flush_i ? '0 : rd_fire ? rd_word.sparsemap : rd_sparsemap_o;
  assign rd_nz_n   = flush_i ? '0 : rd_fire ? rd_word.nonzero_data : rd_nonzero_data_o;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      full              <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      wr_beat           <= '0;
      occupancy_o       <= '0;
      rd_data_valid_o   <= 1'b0;
      rd_sparsemap_o    <= '0;
      rd_nonzero_data_o <= '0;
    end else begin
      full              <= full_n;
      wr_ptr            <= wr_ptr_n;
      rd_ptr            <= rd_ptr_n;
      wr_beat           <= wr_beat_n;
      occupancy_o       <= occ_n;
      rd_data_valid_o   <= rd_dv_n;
      rd_sparsemap_o    <= rd_sm_n;
      rd_nonzero_data_o <= rd_nz_n;
    end
`ifdef IFM_CHUNK_RING_BUF_CLK_GATE_EN
  ifm_clk_gate u_clk_gate (.clk_i(clk_i), .en_i(wr_acc), .gated_clk_o(gated_clk_w));
`else
  assign gated_clk_w = clk_i;
`endif
  always_ff @(posedge gated_clk_w)
    if (wr_acc) mem[wr_ptr][wr_beat] <= '{sparsemap: wr_sparsemap_i, nonzero_data: wr_nonzero_data_i};
endmodule
